// File: rtl/sdram_client_pkg.sv
// Shared types and helpers for the SDRAM bank client: FSM state encoding,
// beat width and the byte-address alignment mask.
package sdram_client_pkg;

  localparam int BEAT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_DATA,
    WR_WAIT,
    WR_DATA,
    DONE
  } state_t;

  // A burst covers 2*burst_len bytes, so those low address bits are cleared.
  function automatic logic [31:0] align_mask(input int burst_len);
    return ~(32'(2 * burst_len) - 32'd1);
  endfunction

endpackage

// File: rtl/sdram_fetch_dly.sv
// Two-stage delay line for write fetch pulses, carrying the beat index so the
// matching data word and byte enables reach the data path two cycles later.
module sdram_fetch_dly
  import sdram_client_pkg::*;
#(
  parameter int BURST_LEN = 2,
  parameter int TAG_W     = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_push,
  input  logic [TAG_W-1:0]            i_tag,
  input  logic [BEAT_W*BURST_LEN-1:0] i_wdata,
  input  logic [2*BURST_LEN-1:0]      i_be,
  output logic                        o_emit_vld,
  output logic [TAG_W-1:0]            o_emit_tag,
  output logic [BEAT_W-1:0]           o_wr_data,
  output logic [1:0]                  o_wr_bena
);

  logic              r_s1_vld;
  logic [TAG_W-1:0]  r_s1_tag;
  logic              r_s2_vld;
  logic [TAG_W-1:0]  r_s2_tag;
  logic [BEAT_W-1:0] r_wr_data;
  logic [1:0]        r_wr_bena;
  logic [BEAT_W-1:0] w_beat_data;
  logic [1:0]        w_beat_bena;

  always_comb begin
    w_beat_data = i_wdata[int'(r_s1_tag)*BEAT_W +: BEAT_W];
    w_beat_bena = i_be[int'(r_s1_tag)*2 +: 2];
  end

  // Outside an emitted slot the data path sees zero enables, so stray fetches write nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_tag  <= '0;
      r_s2_vld  <= 1'b0;
      r_s2_tag  <= '0;
      r_wr_data <= '0;
      r_wr_bena <= 2'b00;
    end else begin
      r_s1_vld <= i_push;
      r_s1_tag <= i_tag;
      r_s2_vld <= r_s1_vld;
      r_s2_tag <= r_s1_tag;
      if (r_s1_vld) begin
        r_wr_data <= w_beat_data;
        r_wr_bena <= w_beat_bena;
      end else begin
        r_wr_data <= '0;
        r_wr_bena <= 2'b00;
      end
    end
  end

  assign o_emit_vld = r_s2_vld;
  assign o_emit_tag = r_s2_tag;
  assign o_wr_data  = r_wr_data;
  assign o_wr_bena  = r_wr_bena;

endmodule

// File: rtl/sdram_bank_client.sv
// Single-transaction req/ack requester for one SDRAM bank port: issues
// rden/wren, assembles read beats, replays write beats and aborts on timeout.
module sdram_bank_client
  import sdram_client_pkg::*;
#(
  parameter int BURST_LEN = 2,
  parameter int TIMEOUT   = 1023
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_req,
  input  logic                        i_we,
  input  logic [31:0]                 i_addr,
  input  logic [BEAT_W*BURST_LEN-1:0] i_wdata,
  input  logic [2*BURST_LEN-1:0]      i_be,
  output logic                        o_busy,
  output logic                        o_ack,
  output logic                        o_err,
  output logic [BEAT_W*BURST_LEN-1:0] o_rdata,
  output logic                        o_rden,
  output logic                        o_wren,
  output logic [31:0]                 o_bank_addr,
  input  logic                        i_valid,
  input  logic                        i_fetch,
  input  logic [BEAT_W-1:0]           i_rd_data,
  output logic [1:0]                  o_wr_bena,
  output logic [BEAT_W-1:0]           o_wr_data
);

  localparam int DW    = BEAT_W * BURST_LEN;
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam int TAG_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] NUM_BEATS = CNT_W'(BURST_LEN);
  localparam logic [TAG_W-1:0] LAST_TAG  = TAG_W'(BURST_LEN - 1);
  localparam logic [TMO_W-1:0] TMO_END   = TMO_W'(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_DROP  = TMO_W'(TIMEOUT - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_beat_cnt;
  logic [TMO_W-1:0]  r_tmo;
  logic [DW-1:0]     r_rbuf;
  logic [DW-1:0]     r_wdata;
  logic [2*BURST_LEN-1:0] r_be;
  logic              r_busy;
  logic              r_ack;
  logic              r_err;
  logic [DW-1:0]     r_rdata;
  logic              r_rden;
  logic              r_wren;
  logic [31:0]       r_bank_addr;

  logic [DW-1:0]     w_rnext;
  logic              w_tmo_hit;
  logic              w_push;
  logic [TAG_W-1:0]  w_tag;
  logic              w_emit_vld;
  logic [TAG_W-1:0]  w_emit_tag;

  always_comb begin
    w_rnext = r_rbuf;
    w_rnext[int'(r_beat_cnt)*BEAT_W +: BEAT_W] = i_rd_data;
  end

  // Fetches enter the delay line only while a write is live and beats remain.
  assign w_tmo_hit = (r_tmo == TMO_END);
  assign w_push    = i_fetch &&
                     (((r_state == WR_WAIT) && !w_tmo_hit) ||
                      ((r_state == WR_DATA) && (r_beat_cnt < NUM_BEATS)));
  assign w_tag     = r_beat_cnt[TAG_W-1:0];

  sdram_fetch_dly #(
    .BURST_LEN (BURST_LEN),
    .TAG_W     (TAG_W)
  ) u_fetch_dly (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_tag      (w_tag),
    .i_wdata    (r_wdata),
    .i_be       (r_be),
    .o_emit_vld (w_emit_vld),
    .o_emit_tag (w_emit_tag),
    .o_wr_data  (o_wr_data),
    .o_wr_bena  (o_wr_bena)
  );

  // The strobe drops one cycle before the abort so the bank sees exactly TIMEOUT strobe cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_beat_cnt  <= '0;
      r_tmo       <= '0;
      r_rbuf      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_busy      <= 1'b0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_rden      <= 1'b0;
      r_wren      <= 1'b0;
      r_bank_addr <= '0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_req) begin
            r_busy      <= 1'b1;
            r_bank_addr <= i_addr & align_mask(BURST_LEN);
            r_wdata     <= i_wdata;
            r_be        <= i_be;
            r_beat_cnt  <= '0;
            r_tmo       <= '0;
            if (i_we) begin
              r_wren  <= 1'b1;
              r_state <= WR_WAIT;
            end else begin
              r_rden  <= 1'b1;
              r_state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (w_tmo_hit) begin
            r_rden  <= 1'b0;
            r_err   <= 1'b1;
            r_ack   <= 1'b1;
            r_state <= DONE;
          end else if (i_valid) begin
            r_rden     <= 1'b0;
            r_rbuf     <= w_rnext;
            r_beat_cnt <= CNT_W'(1);
            if (BURST_LEN == 1) begin
              r_rdata <= w_rnext;
              r_ack   <= 1'b1;
              r_state <= DONE;
            end else begin
              r_state <= RD_DATA;
            end
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
            if (r_tmo == TMO_DROP) r_rden <= 1'b0;
          end
        end
        RD_DATA: begin
          if (i_valid) begin
            r_rbuf     <= w_rnext;
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            if (r_beat_cnt == LAST_BEAT) begin
              r_rdata <= w_rnext;
              r_ack   <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        WR_WAIT: begin
          if (w_tmo_hit) begin
            r_wren  <= 1'b0;
            r_err   <= 1'b1;
            r_ack   <= 1'b1;
            r_state <= DONE;
          end else if (i_fetch) begin
            r_wren     <= 1'b0;
            r_beat_cnt <= CNT_W'(1);
            r_state    <= WR_DATA;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
            if (r_tmo == TMO_DROP) r_wren <= 1'b0;
          end
        end
        WR_DATA: begin
          if (w_push) r_beat_cnt <= r_beat_cnt + CNT_W'(1);
          if (w_emit_vld && (w_emit_tag == LAST_TAG)) begin
            r_ack   <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_err   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_ack       = r_ack;
  assign o_err       = r_err;
  assign o_rdata     = r_rdata;
  assign o_rden      = r_rden;
  assign o_wren      = r_wren;
  assign o_bank_addr = r_bank_addr;

endmodule
